// File: rtl/ripl_haar_h_decim_if.sv
// Actor token interface for the horizontal Haar stage: one pixel input, low/high band outputs.
// The design side uses the slave modport; the environment side uses master.
interface ripl_haar_h_decim_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              In1_SEND;
    logic [DATA_W-1:0] In1_DATA;
    logic [CNT_W-1:0]  In1_COUNT;
    logic              In1_ACK;

    logic              Out1_RDY;
    logic              Out1_ACK;
    logic              Out1_SEND;
    logic [DATA_W-1:0] Out1_DATA;
    logic [CNT_W-1:0]  Out1_COUNT;

    logic              Out2_RDY;
    logic              Out2_ACK;
    logic              Out2_SEND;
    logic [DATA_W-1:0] Out2_DATA;
    logic [CNT_W-1:0]  Out2_COUNT;

    modport slave (
        input  In1_SEND, In1_DATA, In1_COUNT, Out1_RDY, Out1_ACK, Out2_RDY, Out2_ACK,
        output In1_ACK, Out1_SEND, Out1_DATA, Out1_COUNT, Out2_SEND, Out2_DATA, Out2_COUNT
    );

    modport master (
        output In1_SEND, In1_DATA, In1_COUNT, Out1_RDY, Out1_ACK, Out2_RDY, Out2_ACK,
        input  In1_ACK, Out1_SEND, Out1_DATA, Out1_COUNT, Out2_SEND, Out2_DATA, Out2_COUNT
    );
endinterface

// File: rtl/ripl_haar_h_decim.sv
// Horizontal Haar analysis: pairs adjacent pixels of a row into L=(a+b)>>1 and H=(a-b)>>>1, odd tail replicated.
// Latency: L/H pair sent the cycle after its second pixel is consumed; input blocked while a result waits on RDY.
module ripl_haar_h_decim #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 512,
    parameter int CNT_W  = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    ripl_haar_h_decim_if.slave       io
);
    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        EMIT   = 2'd2
    } state_t;

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    state_t            state, state_nxt;
    logic [1:0]        kick_cnt;
    logic              kick_done;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] a_q, l_q, h_q;
    logic              fire, consume, tail, load_a, load_res;
    logic [DATA_W-1:0] pa, pb;
    logic [DATA_W:0]   sum, diff;
    logic              unused_inputs;

    assign unused_inputs = &{1'b0, io.In1_COUNT, io.Out1_ACK, io.Out2_ACK};

    // Saturates at 2: firing starts on the third rising edge after reset release.
    assign kick_done = kick_cnt[1];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            kick_cnt <= 2'd0;
        end else if (!kick_done) begin
            kick_cnt <= kick_cnt + 2'd1;
        end
    end

    assign fire    = (state == EMIT) & io.Out1_RDY & io.Out2_RDY;
    assign consume = kick_done & io.In1_SEND &
                     ((state == WAIT_A) | (state == WAIT_B) | fire);
    assign tail    = (col == COL_LAST);

    // In WAIT_A/EMIT the incoming pixel is 'a'; a tail pixel pairs with itself, giving L=a, H=0.
    assign pa   = (state == WAIT_B) ? a_q : io.In1_DATA;
    assign pb   = io.In1_DATA;
    assign sum  = {1'b0, pa} + {1'b0, pb};
    assign diff = {1'b0, pa} - {1'b0, pb};

    always_comb begin
        state_nxt = state;
        load_a    = 1'b0;
        load_res  = 1'b0;
        case (state)
            WAIT_B: begin
                if (consume) begin
                    load_res  = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (fire) begin
                    state_nxt = WAIT_A;
                    if (consume) begin
                        if (tail) begin
                            load_res  = 1'b1;
                            state_nxt = EMIT;
                        end else begin
                            load_a    = 1'b1;
                            state_nxt = WAIT_B;
                        end
                    end
                end
            end
            default: begin
                if (consume) begin
                    if (tail) begin
                        load_res  = 1'b1;
                        state_nxt = EMIT;
                    end else begin
                        load_a    = 1'b1;
                        state_nxt = WAIT_B;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= WAIT_A;
            col   <= '0;
            a_q   <= '0;
            l_q   <= '0;
            h_q   <= '0;
        end else begin
            state <= state_nxt;
            if (consume) begin
                col <= tail ? '0 : col + COL_W'(1);
            end
            if (load_a) begin
                a_q <= io.In1_DATA;
            end
            if (load_res) begin
                l_q <= sum[DATA_W:1];
                h_q <= diff[DATA_W:1];
            end
        end
    end

    assign io.In1_ACK    = consume;
    assign io.Out1_SEND  = fire;
    assign io.Out2_SEND  = fire;
    assign io.Out1_DATA  = l_q;
    assign io.Out2_DATA  = h_q;
    assign io.Out1_COUNT = CNT_W'(1);
    assign io.Out2_COUNT = CNT_W'(1);
endmodule

// File: tb/tb_ripl_haar_h_decim.sv
// Bench for ripl_haar_h_decim: two instances (row widths 4 and 3) checked every cycle against a pixel-pairing model.
module tb_ripl_haar_h_decim;
    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    ripl_haar_h_decim_if #(.DATA_W(16), .CNT_W(16)) ifa ();
    ripl_haar_h_decim_if #(.DATA_W(16), .CNT_W(16)) ifb ();

    ripl_haar_h_decim #(.DATA_W(16), .IMG_W(4), .CNT_W(16)) u_dut4 (
        .CLK(CLK), .RESET(RESET), .io(ifa.slave)
    );
    ripl_haar_h_decim #(.DATA_W(16), .IMG_W(3), .CNT_W(16)) u_dut3 (
        .CLK(CLK), .RESET(RESET), .io(ifb.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] src0[$];
    logic [15:0] src1[$];
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];

    int   kick = 0;
    int   col[2];
    bit   have_a[2];
    int   held[2];
    int   rdy_mode = 0;
    bit   send_rand = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wid(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic logic [31:0] haar(input int a, input int b);
        int s;
        int d;
        s = (a + b) / 2;
        d = (a - b) >>> 1;
        return {16'(s), 16'(d)};
    endfunction

    function automatic int esize(input int k);
        return (k == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic step_dut(input int k, input logic ack, input logic s1, input logic s2,
                            input logic [15:0] d1, input logic [15:0] d2,
                            input logic [15:0] c1, input logic [15:0] c2,
                            input logic r1, input logic r2, input logic snd, input logic [15:0] din);
        bit pend, fire, eack;
        logic [31:0] f;
        int p;
        pend = esize(k) > 0;
        f    = !pend ? 32'h0 : ((k == 0) ? exp0[0] : exp1[0]);
        fire = pend && r1 && r2;
        eack = (kick >= 2) && !RESET && snd && (!pend || fire);
        chk($sformatf("ack%0d", k), ack, eack);
        chk($sformatf("send1_%0d", k), s1, fire);
        chk($sformatf("send2_%0d", k), s2, fire);
        chk($sformatf("count%0d", k), {c1, c2}, 32'h0001_0001);
        if (pend) chk($sformatf("data%0d", k), {d1, d2}, f);
        if (RESET) chk($sformatf("rstdata%0d", k), {d1, d2}, 32'h0);
        if (fire) begin
            if (k == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
        end
        if (eack) begin
            p = int'(din);
            if (k == 0) void'(src0.pop_front()); else void'(src1.pop_front());
            if (have_a[k]) begin
                f = haar(held[k], p);
                have_a[k] = 0;
            end else if (col[k] == wid(k) - 1) begin
                f = haar(p, p);
            end else begin
                held[k] = p;
                have_a[k] = 1;
            end
            if (!have_a[k]) begin
                if (k == 0) exp0.push_back(f); else exp1.push_back(f);
            end
            col[k] = (col[k] + 1) % wid(k);
        end
    endtask

    task automatic drive();
        ifa.In1_SEND  = (src0.size() > 0) && (send_rand ? ($urandom_range(3) != 0) : 1'b1);
        ifa.In1_DATA  = (src0.size() > 0) ? src0[0] : 16'h0;
        ifb.In1_SEND  = (src1.size() > 0) && (send_rand ? ($urandom_range(3) != 0) : 1'b1);
        ifb.In1_DATA  = (src1.size() > 0) ? src1[0] : 16'h0;
        ifa.In1_COUNT = 16'($urandom);
        ifb.In1_COUNT = 16'($urandom);
        ifa.Out1_ACK  = 1'($urandom); ifa.Out2_ACK = 1'($urandom);
        ifb.Out1_ACK  = 1'($urandom); ifb.Out2_ACK = 1'($urandom);
        case (rdy_mode)
            1: begin
                ifa.Out1_RDY = ($urandom_range(4) != 0); ifa.Out2_RDY = ($urandom_range(4) != 0);
                ifb.Out1_RDY = ($urandom_range(4) != 0); ifb.Out2_RDY = ($urandom_range(4) != 0);
            end
            2: begin
                ifa.Out1_RDY = 1'b1; ifa.Out2_RDY = 1'b0;
                ifb.Out1_RDY = 1'b1; ifb.Out2_RDY = 1'b0;
            end
            default: begin
                ifa.Out1_RDY = 1'b1; ifa.Out2_RDY = 1'b1;
                ifb.Out1_RDY = 1'b1; ifb.Out2_RDY = 1'b1;
            end
        endcase
    endtask

    task automatic tick();
        #1;
        if (RESET) begin
            kick = 0;
            for (int k = 0; k < 2; k++) begin
                col[k] = 0;
                have_a[k] = 0;
            end
            exp0.delete();
            exp1.delete();
        end
        step_dut(0, ifa.In1_ACK, ifa.Out1_SEND, ifa.Out2_SEND, ifa.Out1_DATA, ifa.Out2_DATA,
                 ifa.Out1_COUNT, ifa.Out2_COUNT, ifa.Out1_RDY, ifa.Out2_RDY, ifa.In1_SEND, ifa.In1_DATA);
        step_dut(1, ifb.In1_ACK, ifb.Out1_SEND, ifb.Out2_SEND, ifb.Out1_DATA, ifb.Out2_DATA,
                 ifb.Out1_COUNT, ifb.Out2_COUNT, ifb.Out1_RDY, ifb.Out2_RDY, ifb.In1_SEND, ifb.In1_DATA);
        if (!RESET && kick < 2) kick++;
        @(posedge CLK);
        @(negedge CLK);
        drive();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((src0.size() > 0 || src1.size() > 0 || exp0.size() > 0 || exp1.size() > 0 ||
                have_a[0] || have_a[1]) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 32'h1);
    endtask

    function automatic logic [15:0] rpix();
        case ($urandom_range(5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        RESET = 1'b1;
        for (int k = 0; k < 2; k++) begin
            col[k] = 0; have_a[k] = 0; held[k] = 0;
        end
        drive();
        @(negedge CLK);
        repeat (3) tick();

        // Start-up with SEND held high from release; row width 3 sees a tail per row.
        RESET = 1'b0;
        for (int i = 1; i <= 8; i++) src0.push_back(16'(i));
        foreach (src1[i]) src1.delete(i);
        src1 = '{16'd8, 16'd4, 16'd7, 16'd1, 16'd3, 16'd5};
        drive();
        run_idle(100);

        // Directed pairs and extremes.
        src0 = '{16'd10, 16'd20, 16'd30, 16'd31, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF};
        drive();
        run_idle(100);

        // Out2 held not-ready while results are pending, then released with input waiting.
        src0 = '{16'd100, 16'd50, 16'd60, 16'd70};
        src1 = '{16'd11, 16'd12, 16'd13};
        rdy_mode = 2;
        drive();
        repeat (8) tick();
        rdy_mode = 0;
        drive();
        run_idle(100);

        // Random traffic with random ready and send gaps.
        for (int i = 0; i < 400; i++) src0.push_back(rpix());
        for (int i = 0; i < 300; i++) src1.push_back(rpix());
        rdy_mode = 1;
        send_rand = 1;
        drive();
        run_idle(6000);

        // Reset while holding pixel a=9: it must never appear.
        rdy_mode = 0;
        send_rand = 0;
        src0.push_back(16'd9);
        drive();
        n = 0;
        while (src0.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        chk("hold_timeout", 32'(n < 50), 32'h1);
        RESET = 1'b1;
        drive();
        repeat (2) tick();
        RESET = 1'b0;
        src0 = '{16'd2, 16'd4};
        drive();
        run_idle(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
